baudrate_gen_frac: RTL and testbench

//  Parametrised UART baud-tick generator with a runtime-programmable fractional divisor.

---
 rtl/baudrate_gen_frac.sv | 138 +++++++++++++
 tb/tb_baudrate_gen_frac.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baudrate_gen_frac.sv
// -----------------------------------------------------------------------------
// baudrate_gen_frac
//   UART baud-tick generator with a runtime-programmable fractional divisor.
//   A base counter produces one tick every (div + ext) clocks, where ext is
//   the carry of a fractional accumulator, giving an average period of
//   div + frac/2^FRAC_W. Base ticks drive the RX oversample tick directly and
//   every OVERSAMPLE-th base tick drives the TX bit tick.
//   New divisors land in a shadow register and are applied on a base-tick
//   boundary (or immediately when idle), so a period is never cut short.
//
// Ports
//   clk                   system clock, rising edge
//   rst                   asynchronous reset, active-high
//   I_baudrate_tx_clk_en  enable TX tick generation
//   I_baudrate_rx_clk_en  enable RX tick generation
//   I_div_load            1-cycle strobe: capture I_div_int/I_div_frac to shadow
//   I_div_int             integer divisor (clk cycles per base tick)
//   I_div_frac            fractional divisor, units of 1/2^FRAC_W cycle
//   O_baudrate_tx_clk     1-cycle TX bit tick
//   O_baudrate_rx_clk     1-cycle RX oversample tick
//   O_div_pending         shadow divisor waiting to be applied
// -----------------------------------------------------------------------------
module baudrate_gen_frac #(
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned FRAC_W      = 4,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned DEFAULT_DIV = 27
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              I_baudrate_tx_clk_en,
   input  logic              I_baudrate_rx_clk_en,
   input  logic              I_div_load,
   input  logic [DIV_W-1:0]  I_div_int,
   input  logic [FRAC_W-1:0] I_div_frac,
   output logic              O_baudrate_tx_clk,
   output logic              O_baudrate_rx_clk,
   output logic              O_div_pending
);

   localparam int unsigned      SUB_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
   localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

   logic [DIV_W-1:0]  base_cnt;
   logic [FRAC_W-1:0] acc;
   logic              ext;
   logic [SUB_W-1:0]  tx_sub;
   logic [DIV_W-1:0]  div_act;
   logic [FRAC_W-1:0] frac_act;
   logic [DIV_W-1:0]  shadow_int;
   logic [FRAC_W-1:0] shadow_frac;
   logic              pending;

   logic              active;
   logic [DIV_W-1:0]  div_eff;
   logic [DIV_W:0]    last_cnt;
   logic              base_tick;
   logic [FRAC_W:0]   frac_sum;
   logic              apply_shadow;

   always_comb begin
      active       = I_baudrate_tx_clk_en | I_baudrate_rx_clk_en;
      // Divisors of 0 or 1 would stall or degenerate; run them as 2.
      div_eff      = (div_act < DIV_MIN) ? DIV_MIN : div_act;
      // Terminal count is div_eff + ext - 1; div_eff >= 2 so no underflow.
      last_cnt     = {1'b0, div_eff} - (DIV_W+1)'(1) + (DIV_W+1)'(ext);
      base_tick    = active && ({1'b0, base_cnt} == last_cnt);
      frac_sum     = {1'b0, acc} + {1'b0, frac_act};
      // A load on the transfer edge wins: the fresh shadow waits for the next tick.
      apply_shadow = pending && !I_div_load && (base_tick || !active);
   end

   // Base counter, fractional accumulator and active divisor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_cnt <= '0;
         acc      <= '0;
         ext      <= 1'b0;
         div_act  <= DIV_W'(DEFAULT_DIV);
         frac_act <= '0;
      end else begin
         if (!active) begin
            base_cnt <= '0;
            acc      <= '0;
            ext      <= 1'b0;
         end else if (base_tick) begin
            base_cnt <= '0;
            acc      <= frac_sum[FRAC_W-1:0];
            ext      <= frac_sum[FRAC_W];
         end else begin
            base_cnt <= base_cnt + DIV_W'(1);
         end
         // Applying a new divisor restarts the fractional sequence from zero.
         if (apply_shadow) begin
            div_act  <= shadow_int;
            frac_act <= shadow_frac;
            acc      <= '0;
            ext      <= 1'b0;
         end
      end
   end

   // Shadow divisor and pending flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_int  <= DIV_W'(DEFAULT_DIV);
         shadow_frac <= '0;
         pending     <= 1'b0;
      end else if (I_div_load) begin
         shadow_int  <= I_div_int;
         shadow_frac <= I_div_frac;
         pending     <= 1'b1;
      end else if (apply_shadow) begin
         pending     <= 1'b0;
      end
   end

   // TX sub-counter and registered tick outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_sub            <= '0;
         O_baudrate_rx_clk <= 1'b0;
         O_baudrate_tx_clk <= 1'b0;
      end else begin
         if (!I_baudrate_tx_clk_en) begin
            tx_sub <= '0;
         end else if (base_tick) begin
            tx_sub <= (tx_sub == SUB_LAST) ? '0 : tx_sub + SUB_W'(1);
         end
         O_baudrate_rx_clk <= base_tick & I_baudrate_rx_clk_en;
         O_baudrate_tx_clk <= base_tick & I_baudrate_tx_clk_en & (tx_sub == SUB_LAST);
      end
   end

   assign O_div_pending = pending;

endmodule

// File: tb/tb_baudrate_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baudrate_gen_frac
//   Bench for baudrate_gen_frac. Expected tick edges are queued when the
//   enables/divisors are driven; a scoreboard thread pops them as the DUT
//   ticks. Edge numbering: edge_n counts rising edges, sampled on the falling
//   edge, so a tick registered at edge k is seen with edge_n == k.
// -----------------------------------------------------------------------------
module tb_baudrate_gen_frac;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_en;
   logic        rx_en;
   logic        div_load;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic        o_tx;
   logic        o_rx;
   logic        o_pend;

   int edge_n = 0;
   int n_cmp  = 0;
   int n_bad  = 0;
   int q_rx[$];
   int q_tx[$];

   baudrate_gen_frac #(
      .DIV_W      (16),
      .FRAC_W     (4),
      .OVERSAMPLE (16),
      .DEFAULT_DIV(27)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .I_baudrate_tx_clk_en(tx_en),
      .I_baudrate_rx_clk_en(rx_en),
      .I_div_load          (div_load),
      .I_div_int           (div_int),
      .I_div_frac          (div_frac),
      .O_baudrate_tx_clk   (o_tx),
      .O_baudrate_rx_clk   (o_rx),
      .O_div_pending       (o_pend)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   // Pops expected tick edges as the DUT ticks; flags early, late, missing
   // and unexpected ticks.
   task automatic scoreboard_monitor();
      int exp_e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (o_rx) begin
               n_cmp++;
               if (q_rx.size() == 0) begin
                  n_bad++;
                  $display("FAIL rx_tick: unexpected tick at edge %0d, required none", edge_n);
               end else begin
                  exp_e = q_rx.pop_front();
                  if (edge_n !== exp_e) begin
                     n_bad++;
                     $display("FAIL rx_tick: tick at edge %0d, required edge %0d", edge_n, exp_e);
                  end
               end
            end else if (q_rx.size() > 0 && edge_n >= q_rx[0]) begin
               n_cmp++;
               n_bad++;
               exp_e = q_rx.pop_front();
               $display("FAIL rx_tick: no tick at edge %0d, required tick at edge %0d", edge_n, exp_e);
            end
            if (o_tx) begin
               n_cmp++;
               if (q_tx.size() == 0) begin
                  n_bad++;
                  $display("FAIL tx_tick: unexpected tick at edge %0d, required none", edge_n);
               end else begin
                  exp_e = q_tx.pop_front();
                  if (edge_n !== exp_e) begin
                     n_bad++;
                     $display("FAIL tx_tick: tick at edge %0d, required edge %0d", edge_n, exp_e);
                  end
               end
            end else if (q_tx.size() > 0 && edge_n >= q_tx[0]) begin
               n_cmp++;
               n_bad++;
               exp_e = q_tx.pop_front();
               $display("FAIL tx_tick: no tick at edge %0d, required tick at edge %0d", edge_n, exp_e);
            end
         end
      end
   endtask

   task automatic wait_edge(input int target);
      while (edge_n < target) @(negedge clk);
   endtask

   // Load a divisor while both enables are low; it is active two edges later.
   task automatic load_idle(input int d, input int f);
      @(negedge clk);
      div_int  = 16'(d);
      div_frac = 4'(f);
      div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int seen;
      seen = 0;
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         tx_en    = i[0];
         rx_en    = i[1];
         div_load = (i == 5);
         div_int  = 16'd3;
         if (o_tx || o_rx || o_pend) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL reset_outputs: %0d cycles with an output high, required 0", seen);
      end
      tx_en    = 1'b0;
      rx_en    = 1'b0;
      div_load = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (o_tx || o_rx || o_pend) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL idle_no_ticks: %0d cycles with an output high, required 0", seen);
      end
      n_cmp++;
      if (o_pend !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_pending: got %b, required 0", o_pend);
      end
   endtask

   task automatic test_rx_only();
      int e0;
      @(negedge clk);
      div_int  = 16'd10;
      div_frac = 4'd0;
      div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      n_cmp++;
      if (o_pend !== 1'b1) begin
         n_bad++;
         $display("FAIL pending_set_idle: got %b, required 1", o_pend);
      end
      @(negedge clk);
      n_cmp++;
      if (o_pend !== 1'b0) begin
         n_bad++;
         $display("FAIL pending_clear_idle: got %b, required 0", o_pend);
      end
      rx_en = 1'b1;
      e0 = edge_n;
      for (int k = 1; k <= 3; k++) q_rx.push_back(e0 + 10 * k);
      wait_edge(e0 + 36);
      rx_en = 1'b0;
      n_cmp++;
      if (q_rx.size() !== 0 || q_tx.size() !== 0) begin
         n_bad++;
         $display("FAIL rx_only_drain: %0d rx / %0d tx ticks outstanding, required 0", q_rx.size(), q_tx.size());
      end
   endtask

   task automatic test_both();
      int e0;
      @(negedge clk);
      tx_en = 1'b1;
      rx_en = 1'b1;
      e0 = edge_n;
      for (int k = 1; k <= 32; k++) q_rx.push_back(e0 + 10 * k);
      q_tx.push_back(e0 + 160);
      q_tx.push_back(e0 + 320);
      wait_edge(e0 + 325);
      tx_en = 1'b0;
      rx_en = 1'b0;
      n_cmp++;
      if (q_rx.size() !== 0 || q_tx.size() !== 0) begin
         n_bad++;
         $display("FAIL both_drain: %0d rx / %0d tx ticks outstanding, required 0", q_rx.size(), q_tx.size());
      end
   endtask

   task automatic test_frac();
      int e0;
      int t;
      int per[7];
      per = '{10, 10, 11, 10, 11, 10, 11};
      load_idle(10, 8);
      rx_en = 1'b1;
      e0 = edge_n;
      t  = e0;
      for (int k = 0; k < 7; k++) begin
         t += per[k];
         q_rx.push_back(t);
      end
      wait_edge(t + 5);
      rx_en = 1'b0;
      n_cmp++;
      if (q_rx.size() !== 0) begin
         n_bad++;
         $display("FAIL frac_drain: %0d rx ticks outstanding, required 0", q_rx.size());
      end
   endtask

   task automatic test_div_update();
      int e0;
      load_idle(10, 0);
      rx_en = 1'b1;
      e0 = edge_n;
      q_rx.push_back(e0 + 10);
      q_rx.push_back(e0 + 20);
      q_rx.push_back(e0 + 40);
      q_rx.push_back(e0 + 60);
      wait_edge(e0 + 15);
      div_int  = 16'd20;
      div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      n_cmp++;
      if (o_pend !== 1'b1) begin
         n_bad++;
         $display("FAIL update_pending_set: got %b, required 1", o_pend);
      end
      wait_edge(e0 + 19);
      n_cmp++;
      if (o_pend !== 1'b1) begin
         n_bad++;
         $display("FAIL update_pending_held: got %b, required 1", o_pend);
      end
      wait_edge(e0 + 20);
      n_cmp++;
      if (o_pend !== 1'b0) begin
         n_bad++;
         $display("FAIL update_pending_clear: got %b, required 0", o_pend);
      end
      wait_edge(e0 + 66);
      rx_en = 1'b0;
      n_cmp++;
      if (q_rx.size() !== 0) begin
         n_bad++;
         $display("FAIL update_drain: %0d rx ticks outstanding, required 0", q_rx.size());
      end
   endtask

   // Load strobe sampled on the same edge as a base tick (div is 20 here).
   task automatic test_load_on_tick();
      int e0;
      @(negedge clk);
      rx_en = 1'b1;
      e0 = edge_n;
      q_rx.push_back(e0 + 20);
      q_rx.push_back(e0 + 40);
      q_rx.push_back(e0 + 45);
      q_rx.push_back(e0 + 50);
      q_rx.push_back(e0 + 55);
      wait_edge(e0 + 19);
      div_int  = 16'd5;
      div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
      n_cmp++;
      if (o_pend !== 1'b1) begin
         n_bad++;
         $display("FAIL tick_load_pending_set: got %b, required 1", o_pend);
      end
      wait_edge(e0 + 39);
      n_cmp++;
      if (o_pend !== 1'b1) begin
         n_bad++;
         $display("FAIL tick_load_pending_held: got %b, required 1", o_pend);
      end
      wait_edge(e0 + 40);
      n_cmp++;
      if (o_pend !== 1'b0) begin
         n_bad++;
         $display("FAIL tick_load_pending_clear: got %b, required 0", o_pend);
      end
      wait_edge(e0 + 58);
      rx_en = 1'b0;
      n_cmp++;
      if (q_rx.size() !== 0) begin
         n_bad++;
         $display("FAIL tick_load_drain: %0d rx ticks outstanding, required 0", q_rx.size());
      end
   endtask

   // div=0 clamps to 2; async reset mid-tick; reset restores the default divisor.
   task automatic test_clamp_reset();
      int e0;
      int r;
      load_idle(0, 0);
      rx_en = 1'b1;
      e0 = edge_n;
      for (int k = 1; k <= 6; k++) q_rx.push_back(e0 + 2 * k);
      wait_edge(e0 + 12);
      #2;
      n_cmp++;
      if (o_rx !== 1'b1) begin
         n_bad++;
         $display("FAIL tick_before_reset: got %b, required 1", o_rx);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (o_rx !== 1'b0 || o_tx !== 1'b0 || o_pend !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset_drop: rx=%b tx=%b pend=%b, required all 0", o_rx, o_tx, o_pend);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      r = edge_n;
      q_rx.push_back(r + 27);
      q_rx.push_back(r + 54);
      wait_edge(r + 58);
      n_cmp++;
      if (q_rx.size() !== 0) begin
         n_bad++;
         $display("FAIL reset_restart_drain: %0d rx ticks outstanding, required 0", q_rx.size());
      end
   endtask

   // Drop the enable mid-period, then re-enable: full latency, no partial tick.
   task automatic test_enable_drop();
      int e1;
      wait_edge(edge_n + 10);
      rx_en = 1'b0;
      repeat (40) @(negedge clk);
      rx_en = 1'b1;
      e1 = edge_n;
      q_rx.push_back(e1 + 27);
      wait_edge(e1 + 30);
      rx_en = 1'b0;
      n_cmp++;
      if (q_rx.size() !== 0) begin
         n_bad++;
         $display("FAIL reenable_drain: %0d rx ticks outstanding, required 0", q_rx.size());
      end
   endtask

   initial begin
      rst      = 1'b1;
      tx_en    = 1'b0;
      rx_en    = 1'b0;
      div_load = 1'b0;
      div_int  = '0;
      div_frac = '0;
      fork
         scoreboard_monitor();
      join_none
      test_reset();
      test_rx_only();
      test_both();
      test_frac();
      test_div_update();
      test_load_on_tick();
      test_clamp_reset();
      test_enable_drop();
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
